fft8_sequencer: RTL
===================

Name: fft8_sequencer

Overview:
- Control sequencer for the 8-point radix-2 decimation-in-time FFT engine.
- Walks 3 stages × 4 butterflies over an in-place 8-word sample RAM. Input is stored in bit-reversed order.
- Per butterfly it issues dual read addresses plus the twiddle ROM index (0..3, the ROM's valid range). It then issues the matching dual write-back addresses after the butterfly pipeline latency.
- Owns start/busy/done handshake with the host controller; stalls between stages so the next stage never reads before the previous stage's last write.

Parameters:
- BF_LATENCY, 2, cycles from rd_en (read issue) to wr_en (write-back) of the same butterfly; legal range 1..8.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a transform; sampled only in IDLE.
- busy  out  1  high while the transform is in progress.
- done  out  1  one-cycle pulse when the transform completes.
- rd_en  out  1  butterfly read issue strobe.
- rd_addr_a  out  3  upper butterfly input address.
- rd_addr_b  out  3  lower butterfly input address.
- twid_index  out  3  twiddle ROM index, valid with rd_en.
- wr_en  out  1  butterfly write-back strobe.
- wr_addr_a  out  3  upper write-back address.
- wr_addr_b  out  3  lower write-back address.
- stage  out  2  current stage (0..2) of the issue side.

Behaviour:
- Reset (asynchronous, immediate): busy=0, done=0, rd_en=0, wr_en=0, all address outputs and twid_index=0, stage=0, state=IDLE. Delay-line valid bits are cleared, so in-flight writes are squashed. Reset mid-transform therefore produces no further wr_en.
- All outputs are registered.
- States:
  - IDLE: busy=0; start=1 → ISSUE, stage=0, k=0.
  - ISSUE: rd_en=1 for k=0..3, one butterfly per cycle. After k=3 → DRAIN, with drain counter loaded to BF_LATENCY.
  - DRAIN: rd_en=0; counter decrements each cycle. On expiry:
    - stage<2 → ISSUE with stage+1, k=0.
    - stage=2 → DONE.
  - DONE: done=1 and busy=0 for exactly one cycle → IDLE.
- Address generation for stage s, butterfly k, with span = 1<<s:
  - pos = k & (span-1)
  - grp = k >> s
  - rd_addr_a = grp*2*span + pos
  - rd_addr_b = rd_addr_a + span
  - twid_index = pos << (2-s)
  - Resulting sequences:
    - s0: pairs (0,1)(2,3)(4,5)(6,7), tw 0,0,0,0.
    - s1: pairs (0,2)(1,3)(4,6)(5,7), tw 0,2,0,2.
    - s2: pairs (0,4)(1,5)(2,6)(3,7), tw 0,1,2,3.
  - twid_index never exceeds 3.
- Write side: wr_en, wr_addr_a and wr_addr_b equal rd_en, rd_addr_a and rd_addr_b delayed by exactly BF_LATENCY cycles through a shift register.
- Timing: start sampled high at edge 0 gives the first rd_en at cycle 1.
  - Stage s issues in cycles 1+s*(4+L) .. 4+s*(4+L), where L = BF_LATENCY.
  - The next stage's first read occurs the cycle after the previous stage's last write.
  - Last write at cycle 4+2*(4+L)+L; done at 13+3L (L=2: done at cycle 19).
- busy is high from cycle 1 through the cycle of the last wr_en inclusive.
- start while busy or in DONE: ignored, no queuing.
- start held high continuously: a new transform begins the cycle after done (IDLE sampled with start=1).
- rd_en and wr_en may be high in the same cycle. This happens only on different stages' boundary-free overlap within a stage; addresses never collide within a stage.

Test Plan:
- Reset then single start pulse, L=2 → exactly 12 rd_en and 12 wr_en pulses. Sequences match:
  - rd: (0,1)(2,3)(4,5)(6,7) / (0,2)(1,3)(4,6)(5,7) / (0,4)(1,5)(2,6)(3,7)
  - twid_index: 0,0,0,0 / 0,2,0,2 / 0,1,2,3
  - done pulse at cycle 19; busy high cycles 1..18.
- Every wr_en pulse → wr_addr equals the rd_addr issued exactly BF_LATENCY cycles earlier. Check with BF_LATENCY=1 (done at cycle 16) and BF_LATENCY=5 (done at cycle 28).
- Stage boundary check → for every stage s>0, the first rd_en cycle is strictly after stage s-1's last wr_en cycle.
- start pulsed during busy at cycles 5 and 12 → ignored, single done. start held high for 40 cycles with L=2 → second transform's first rd_en at cycle 21.
- rst asserted asynchronously at cycle 8 (mid-stage 1) for 1 cycle → all outputs 0 immediately, no wr_en afterward. A later start runs a clean full transform from stage 0.
- Random reference model compare over 200 starts with random start gaps → no twid_index>3, no address outside 0..7, done count equals accepted start count.

Source files
------------

// File: rtl/fft8_sequencer.sv
// Control sequencer for an 8-point radix-2 DIT FFT engine.
// Walks 3 stages x 4 butterflies over an in-place 8-word RAM, issuing dual
// read addresses with a twiddle index, then the matching write-back
// addresses BF_LATENCY cycles later. Drains between stages so a stage never
// reads a word before the previous stage has written it back.
module fft8_sequencer #(
  parameter int BF_LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       rd_en,
  output logic [2:0] rd_addr_a,
  output logic [2:0] rd_addr_b,
  output logic [2:0] twid_index,
  output logic       wr_en,
  output logic [2:0] wr_addr_a,
  output logic [2:0] wr_addr_b,
  output logic [1:0] stage
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t     state_q, state_d;
  logic [1:0] stg_q, stg_d;
  logic [1:0] k_q, k_d;
  logic [3:0] cnt_q, cnt_d;

  logic       busy_q, done_q, rd_en_q;
  logic [2:0] rd_a_q, rd_b_q, tw_q;
  logic [1:0] stage_out_q;

  logic [BF_LATENCY-1:0] dly_en_q;
  logic [2:0]            dly_a_q [BF_LATENCY];
  logic [2:0]            dly_b_q [BF_LATENCY];

  logic       issue_c;
  logic [2:0] span_c, pos_c, grp_c, grp_sh_c, addr_a_c, addr_b_c, twid_c;
  logic [1:0] tw_sh_c;

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      stg_q   <= 2'd0;
      k_q     <= 2'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      stg_q   <= stg_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: issue 4 butterflies, drain the pipeline, next stage.
  always_comb begin
    state_d = state_q;
    stg_d   = stg_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          stg_d   = 2'd0;
          k_d     = 2'd0;
        end
      end
      ISSUE: begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d = DRAIN;
          cnt_d   = 4'(BF_LATENCY);
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (stg_q == 2'd2) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            stg_d   = stg_q + 2'd1;
            k_d     = 2'd0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Butterfly address and twiddle generation for (stage, k).
  always_comb begin
    issue_c  = (state_q == ISSUE);
    span_c   = 3'd1 << stg_q;
    pos_c    = {1'b0, k_q} & (span_c - 3'd1);
    grp_c    = {1'b0, k_q} >> stg_q;
    grp_sh_c = {1'b0, stg_q} + 3'd1;
    addr_a_c = (grp_c << grp_sh_c) + pos_c;
    addr_b_c = addr_a_c + span_c;
    tw_sh_c  = 2'd2 - stg_q;
    twid_c   = pos_c << tw_sh_c;
  end

  // Registered issue-side outputs and handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_a_q      <= 3'd0;
      rd_b_q      <= 3'd0;
      tw_q        <= 3'd0;
      stage_out_q <= 2'd0;
    end else begin
      busy_q      <= (state_q == ISSUE) || (state_q == DRAIN);
      done_q      <= (state_q == DONE);
      rd_en_q     <= issue_c;
      rd_a_q      <= issue_c ? addr_a_c : 3'd0;
      rd_b_q      <= issue_c ? addr_b_c : 3'd0;
      tw_q        <= issue_c ? twid_c : 3'd0;
      stage_out_q <= stg_q;
    end
  end

  // Write-back delay line; reset squashes any butterflies still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_en_q <= '0;
      for (int i = 0; i < BF_LATENCY; i++) begin
        dly_a_q[i] <= 3'd0;
        dly_b_q[i] <= 3'd0;
      end
    end else begin
      dly_en_q[0] <= rd_en_q;
      dly_a_q[0]  <= rd_a_q;
      dly_b_q[0]  <= rd_b_q;
      for (int i = 1; i < BF_LATENCY; i++) begin
        dly_en_q[i] <= dly_en_q[i-1];
        dly_a_q[i]  <= dly_a_q[i-1];
        dly_b_q[i]  <= dly_b_q[i-1];
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rd_en      = rd_en_q;
  assign rd_addr_a  = rd_a_q;
  assign rd_addr_b  = rd_b_q;
  assign twid_index = tw_q;
  assign stage      = stage_out_q;
  assign wr_en      = dly_en_q[BF_LATENCY-1];
  assign wr_addr_a  = dly_a_q[BF_LATENCY-1];
  assign wr_addr_b  = dly_b_q[BF_LATENCY-1];

endmodule
